// File: rtl/midi_voice_alloc.sv
// Polyphonic MIDI voice allocator: note-on/off/all-off into an oldest-steal voice table.
// Define MIDI_CHANNEL_FILTER_EN to accept only packets on CHANNEL (default: omni).
module midi_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int CHANNEL    = 0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [31:0]             PKT_DATA,
    input  logic                    PKT_VALID,
    output logic                    PKT_READY,
    output logic [7*NUM_VOICES-1:0] VOICE_NOTE,
    output logic [7*NUM_VOICES-1:0] VOICE_VEL,
    output logic [NUM_VOICES-1:0]   VOICE_GATE,
    output logic                    UPDATE,
    output logic                    STOLE
);

    localparam int RW = $clog2(NUM_VOICES);
    localparam logic [RW-1:0] LAST = RW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_SEARCH, S_COMMIT} state_e;
    typedef enum logic [1:0] {C_NONE, C_ON, C_OFF, C_ALL} cmd_e;

    state_e state_q, state_d;
    cmd_e   cmd_q, cmd_d;
    logic [3:0] cin_q, cin_d;
    logic [6:0] d1_q, d1_d;
    logic [6:0] d2_q, d2_d;
    logic [RW-1:0] idx_q, idx_d;
    logic          mfound_q, mfound_d;
    logic [RW-1:0] midx_q, midx_d;
    logic          ffound_q, ffound_d;
    logic [RW-1:0] fidx_q, fidx_d;
    logic [RW-1:0] oidx_q, oidx_d;
    logic [RW-1:0] orank_q, orank_d;
    logic [6:0]    note_q [NUM_VOICES];
    logic [6:0]    note_d [NUM_VOICES];
    logic [6:0]    vel_q  [NUM_VOICES];
    logic [6:0]    vel_d  [NUM_VOICES];
    logic [RW-1:0] rank_q [NUM_VOICES];
    logic [RW-1:0] rank_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic upd_q, upd_d;
    logic stole_q, stole_d;
    logic [RW-1:0] tgt;
    logic          chg;

`ifdef MIDI_CHANNEL_FILTER_EN
    logic [3:0] chan_q, chan_d;
    logic unused_bits;
    assign unused_bits = ^{PKT_DATA[31:28], PKT_DATA[23:20],
                           PKT_DATA[15], PKT_DATA[7]};
`else
    logic unused_bits;
    assign unused_bits = ^{PKT_DATA[31:28], PKT_DATA[23:16],
                           PKT_DATA[15], PKT_DATA[7], 4'(CHANNEL)};
`endif

    // NOTE_ON target priority: retrigger a sounding match, else a free voice, else steal.
    assign tgt = mfound_q ? midx_q : (ffound_q ? fidx_q : oidx_q);
    assign chg = !gate_q[tgt] || (note_q[tgt] != d1_q) || (vel_q[tgt] != d2_q);

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cin_d    = cin_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        idx_d    = idx_q;
        mfound_d = mfound_q;
        midx_d   = midx_q;
        ffound_d = ffound_q;
        fidx_d   = fidx_q;
        oidx_d   = oidx_q;
        orank_d  = orank_q;
        note_d   = note_q;
        vel_d    = vel_q;
        rank_d   = rank_q;
        gate_d   = gate_q;
        upd_d    = 1'b0;
        stole_d  = 1'b0;
`ifdef MIDI_CHANNEL_FILTER_EN
        chan_d   = chan_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (PKT_VALID) begin
                    cin_d   = PKT_DATA[27:24];
                    d1_d    = PKT_DATA[14:8];
                    d2_d    = PKT_DATA[6:0];
`ifdef MIDI_CHANNEL_FILTER_EN
                    chan_d  = PKT_DATA[19:16];
`endif
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                idx_d    = '0;
                mfound_d = 1'b0;
                midx_d   = '0;
                ffound_d = 1'b0;
                fidx_d   = '0;
                oidx_d   = '0;
                orank_d  = '0;
                cmd_d    = C_NONE;
                if (cin_q == 4'h9 && d2_q != 7'd0)
                    cmd_d = C_ON;
                else if (cin_q == 4'h8 || cin_q == 4'h9)
                    cmd_d = C_OFF;
                else if (cin_q == 4'hB && d1_q == 7'd123)
                    cmd_d = C_ALL;
`ifdef MIDI_CHANNEL_FILTER_EN
                if (chan_q != 4'(CHANNEL))
                    cmd_d = C_NONE;
`endif
                unique case (cmd_d)
                    C_NONE:  state_d = S_IDLE;
                    C_ALL:   state_d = S_COMMIT;
                    default: state_d = S_SEARCH;
                endcase
            end
            S_SEARCH: begin
                if (!mfound_q && gate_q[idx_q] && note_q[idx_q] == d1_q) begin
                    mfound_d = 1'b1;
                    midx_d   = idx_q;
                end
                if (!ffound_q && !gate_q[idx_q]) begin
                    ffound_d = 1'b1;
                    fidx_d   = idx_q;
                end
                if (rank_q[idx_q] >= orank_q) begin
                    oidx_d  = idx_q;
                    orank_d = rank_q[idx_q];
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST)
                    state_d = S_COMMIT;
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                unique case (cmd_q)
                    C_ON: begin
                        note_d[tgt] = d1_q;
                        vel_d[tgt]  = d2_q;
                        gate_d[tgt] = 1'b1;
                        for (int j = 0; j < NUM_VOICES; j++)
                            if (rank_q[j] < rank_q[tgt])
                                rank_d[j] = rank_q[j] + 1'b1;
                        rank_d[tgt] = '0;
                        upd_d   = chg;
                        stole_d = !mfound_q && !ffound_q;
                    end
                    C_OFF: begin
                        if (mfound_q) begin
                            gate_d[midx_q] = 1'b0;
                            upd_d          = 1'b1;
                        end
                    end
                    C_ALL: begin
                        gate_d = '0;
                        upd_d  = |gate_q;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cmd_q    <= C_NONE;
            cin_q    <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            idx_q    <= '0;
            mfound_q <= 1'b0;
            midx_q   <= '0;
            ffound_q <= 1'b0;
            fidx_q   <= '0;
            oidx_q   <= '0;
            orank_q  <= '0;
            gate_q   <= '0;
            upd_q    <= 1'b0;
            stole_q  <= 1'b0;
`ifdef MIDI_CHANNEL_FILTER_EN
            chan_q   <= '0;
`endif
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                rank_q[i] <= RW'(NUM_VOICES - 1 - i);
            end
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            cin_q    <= cin_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            idx_q    <= idx_d;
            mfound_q <= mfound_d;
            midx_q   <= midx_d;
            ffound_q <= ffound_d;
            fidx_q   <= fidx_d;
            oidx_q   <= oidx_d;
            orank_q  <= orank_d;
            gate_q   <= gate_d;
            upd_q    <= upd_d;
            stole_q  <= stole_d;
`ifdef MIDI_CHANNEL_FILTER_EN
            chan_q   <= chan_d;
`endif
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= note_d[i];
                vel_q[i]  <= vel_d[i];
                rank_q[i] <= rank_d[i];
            end
        end
    end

    always_comb begin
        VOICE_NOTE = '0;
        VOICE_VEL  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            VOICE_NOTE[7*i +: 7] = note_q[i];
            VOICE_VEL[7*i +: 7]  = vel_q[i];
        end
    end

    assign VOICE_GATE = gate_q;
    assign PKT_READY  = (state_q == S_IDLE);
    assign UPDATE     = upd_q;
    assign STOLE      = stole_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: directed scenarios plus random packets against
// an LRU-queue model of the voice table.
module tb_midi_voice_alloc;

    localparam int N = 4;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [31:0]       PKT_DATA;
    logic              PKT_VALID;
    logic              PKT_READY;
    logic [7*N-1:0]    VOICE_NOTE;
    logic [7*N-1:0]    VOICE_VEL;
    logic [N-1:0]      VOICE_GATE;
    logic              UPDATE;
    logic              STOLE;

    midi_voice_alloc #(.NUM_VOICES(N), .CHANNEL(0)) dut (
        .CLK(CLK), .RESET(RESET), .PKT_DATA(PKT_DATA), .PKT_VALID(PKT_VALID),
        .PKT_READY(PKT_READY), .VOICE_NOTE(VOICE_NOTE), .VOICE_VEL(VOICE_VEL),
        .VOICE_GATE(VOICE_GATE), .UPDATE(UPDATE), .STOLE(STOLE)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    int m_note [N];
    int m_vel  [N];
    bit m_gate [N];
    int lru [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        lru = {};
        for (int i = 0; i < N; i++) begin
            m_note[i] = 0;
            m_vel[i]  = 0;
            m_gate[i] = 1'b0;
        end
        for (int i = N - 1; i >= 0; i--) lru.push_back(i);
    endfunction

    function automatic void model_apply(input logic [31:0] p, output int rdy,
                                        output bit upd, output bit st);
        int cin = int'(p[27:24]);
        int d1 = int'(p[14:8]);
        int d2 = int'(p[6:0]);
        bit on = (cin == 9) && (d2 != 0);
        bit off = (cin == 8) || ((cin == 9) && (d2 == 0));
        bit all = (cin == 11) && (d1 == 123);
        int match = -1;
        int free = -1;
        int v;
`ifdef MIDI_CHANNEL_FILTER_EN
        if (p[19:16] != 4'd0) begin
            on = 0; off = 0; all = 0;
        end
`endif
        upd = 0;
        st = 0;
        rdy = (on || off) ? N + 3 : (all ? 3 : 2);
        for (int i = N - 1; i >= 0; i--) begin
            if (m_gate[i] && m_note[i] == d1) match = i;
            if (!m_gate[i]) free = i;
        end
        if (on) begin
            v = (match >= 0) ? match : ((free >= 0) ? free : lru[$]);
            st = (match < 0) && (free < 0);
            upd = !m_gate[v] || m_note[v] != d1 || m_vel[v] != d2;
            m_note[v] = d1;
            m_vel[v] = d2;
            m_gate[v] = 1'b1;
            for (int k = 0; k < lru.size(); k++)
                if (lru[k] == v) begin
                    lru.delete(k);
                    break;
                end
            lru.push_front(v);
        end else if (off) begin
            if (match >= 0) begin
                m_gate[match] = 1'b0;
                upd = 1;
            end
        end else if (all) begin
            for (int i = 0; i < N; i++) begin
                if (m_gate[i]) upd = 1;
                m_gate[i] = 1'b0;
            end
        end
    endfunction

    function automatic logic [7*N-1:0] pk(input bit vel);
        logic [7*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[7*i +: 7] = 7'(vel ? m_vel[i] : m_note[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] pk_gate();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = m_gate[i];
        return r;
    endfunction

    task automatic xfer(input logic [31:0] p, output int rk, output int uk,
                        output int un, output logic st);
        int w = 0;
        @(negedge CLK);
        while (!PKT_READY && w < 50) begin
            @(negedge CLK);
            w++;
        end
        PKT_DATA = p;
        PKT_VALID = 1'b1;
        @(posedge CLK);
        #1 PKT_VALID = 1'b0;
        rk = 0; uk = 0; un = 0; st = 1'b0;
        for (int k = 1; k <= 20 && rk == 0; k++) begin
            @(negedge CLK);
            if (UPDATE) begin
                un++;
                uk = k;
                st = STOLE;
            end
            if (PKT_READY) rk = k;
        end
    endtask

    task automatic check_table(input string tag);
        chk({tag, ".note"}, VOICE_NOTE, pk(0));
        chk({tag, ".vel"}, VOICE_VEL, pk(1));
        chk({tag, ".gate"}, VOICE_GATE, pk_gate());
    endtask

    task automatic do_pkt(input logic [31:0] p, input string tag);
        int er, rk, uk, un;
        bit eu, es;
        logic st;
        model_apply(p, er, eu, es);
        xfer(p, rk, uk, un, st);
        chk({tag, ".rdy"}, rk, er);
        chk({tag, ".upd_n"}, un, eu);
        if (eu) chk({tag, ".upd_cyc"}, uk, er);
        chk({tag, ".stole"}, st, es);
        check_table(tag);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".ready"}, PKT_READY, 1);
        chk({tag, ".upd"}, UPDATE, 0);
        chk({tag, ".stole"}, STOLE, 0);
        check_table(tag);
    endtask

    initial begin
        int un;
        logic [31:0] p;
        logic [7:0] d1b, d2b;
        logic [3:0] cin;
        RESET = 1'b1;
        PKT_VALID = 1'b0;
        PKT_DATA = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        check_reset_state("rst_hold");
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_state("rst_rel");

        do_pkt(32'h09903C64, "on60");
        chk("on60.v0note", VOICE_NOTE[6:0], 60);

        do_pkt(32'h09903E50, "on62");
        do_pkt(32'h09904050, "on64");
        do_pkt(32'h09904150, "on65");
        do_pkt(32'h09904350, "steal67");
        chk("steal67.v0note", VOICE_NOTE[6:0], 67);

        do_reset();
        do_pkt(32'h09903C64, "vz_on");
        do_pkt(32'h09903C00, "vz_off1");
        chk("vz.v0note", VOICE_NOTE[6:0], 60);
        do_pkt(32'h09903C00, "vz_off2");

        do_reset();
        do_pkt(32'h09903C64, "rt_on60");
        do_pkt(32'h09903E40, "rt_on62");
        do_pkt(32'h09903C14, "rt_re60");
        chk("rt.v0vel", VOICE_VEL[6:0], 20);
        do_pkt(32'h09904040, "rt_on64");
        do_pkt(32'h09904140, "rt_on65");
        do_pkt(32'h09904340, "rt_steal");
        chk("rt.v1note", VOICE_NOTE[13:7], 67);

        do_reset();
        do_pkt(32'h09903C64, "ao_a");
        do_pkt(32'h09903E64, "ao_b");
        do_pkt(32'h09904064, "ao_c");
        do_pkt(32'h0BB07B00, "alloff");
        do_pkt(32'h0BB00700, "cc7_ign");
        do_pkt(32'h0BB07B00, "alloff_idle");

        do_reset();
        do_pkt(32'h09913C64, "chan1");

        do_pkt(32'h09904250, "pre_abort");
        @(negedge CLK);
        PKT_DATA = 32'h09904450;
        PKT_VALID = 1'b1;
        @(posedge CLK);
        #1 PKT_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("abort.busy", PKT_READY, 0);
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        check_reset_state("abort_rst");
        RESET = 1'b0;
        un = 0;
        repeat (10) begin
            @(negedge CLK);
            if (UPDATE) un++;
        end
        chk("abort.no_upd", un, 0);
        check_table("abort_after");
        do_pkt(32'h09903C64, "post_abort");

        for (int t = 0; t < 200; t++) begin
            int sel = int'($urandom_range(0, 9));
            cin = (sel < 4) ? 4'h9 : (sel < 6) ? 4'h8 : (sel < 8) ? 4'hB : 4'($urandom);
            if (cin == 4'hB && $urandom_range(0, 1) == 1)
                d1b = {1'($urandom), 7'd123};
            else
                d1b = {1'($urandom), 7'(60 + $urandom_range(0, 7))};
            d2b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            p = {4'($urandom), cin, 4'h8 + 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 1)), d1b, d2b};
            do_pkt(p, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
